// File: rtl/debug_run_controller.sv
// rtl/debug_run_controller.sv - debug unit run/step/halt sequencer and register-bank UART dumper
module debug_run_controller #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_tx_busy,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_program_end,
  input  logic [DATA_WIDTH-1:0] i_reg_content,
  output logic                  o_halt,
  output logic [ADDR_WIDTH-1:0] o_reg_read,
  output logic                  o_busy,
  output logic                  o_program_done
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    S_HALTED, S_RUN, S_STEP, S_DUMP_ADDR,
    S_DUMP_LATCH, S_DUMP_SEND, S_DUMP_GUARD, S_DUMP_WAIT
  } state_t;

  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_byte_cnt;
  logic [ADDR_WIDTH-1:0] r_reg_cnt;

  logic w_cmd_run, w_cmd_step, w_cmd_halt, w_cmd_dump;
  logic w_set_done, w_dump_start, w_latch, w_send, w_shift, w_next_reg, w_dump_end;

  assign w_cmd_run  = i_rx_valid && (i_rx_data == 8'h43);
  assign w_cmd_step = i_rx_valid && (i_rx_data == 8'h53);
  assign w_cmd_halt = i_rx_valid && (i_rx_data == 8'h48);
  assign w_cmd_dump = i_rx_valid && (i_rx_data == 8'h52);

  // The pipeline only advances in RUN and for the single STEP cycle.
  assign o_halt     = !((r_state == S_RUN) || (r_state == S_STEP));
  assign o_reg_read = r_reg_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_HALTED;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_set_done   = 1'b0;
    w_dump_start = 1'b0;
    w_latch      = 1'b0;
    w_send       = 1'b0;
    w_shift      = 1'b0;
    w_next_reg   = 1'b0;
    w_dump_end   = 1'b0;
    case (r_state)
      S_HALTED: begin
        if (w_cmd_run && !o_program_done) begin
          w_next = S_RUN;
        end else if (w_cmd_step && !o_program_done) begin
          w_next = S_STEP;
        end else if (w_cmd_dump) begin
          w_next       = S_DUMP_ADDR;
          w_dump_start = 1'b1;
        end
      end
      S_RUN: begin
        if (i_program_end) begin
          w_set_done   = 1'b1;
          w_dump_start = 1'b1;
          w_next       = S_DUMP_ADDR;
        end else if (w_cmd_halt) begin
          w_next = S_HALTED;
        end else if (w_cmd_dump) begin
          w_dump_start = 1'b1;
          w_next       = S_DUMP_ADDR;
        end
      end
      S_STEP: begin
        if (i_program_end) begin
          w_set_done   = 1'b1;
          w_dump_start = 1'b1;
          w_next       = S_DUMP_ADDR;
        end else begin
          w_next = S_HALTED;
        end
      end
      S_DUMP_ADDR:  w_next = S_DUMP_LATCH;
      S_DUMP_LATCH: begin
        w_latch = 1'b1;
        w_next  = S_DUMP_SEND;
      end
      S_DUMP_SEND: begin
        if (!i_tx_busy) begin
          w_send = 1'b1;
          w_next = S_DUMP_GUARD;
        end
      end
      // Gives the transmitter a cycle to raise busy before it is polled.
      S_DUMP_GUARD: w_next = S_DUMP_WAIT;
      S_DUMP_WAIT: begin
        if (!i_tx_busy) begin
          if (r_byte_cnt != '0) begin
            w_shift = 1'b1;
            w_next  = S_DUMP_SEND;
          end else if (r_reg_cnt == ADDR_WIDTH'(NUM_REGS - 1)) begin
            w_dump_end = 1'b1;
            w_next     = S_HALTED;
          end else begin
            w_next_reg = 1'b1;
            w_next     = S_DUMP_ADDR;
          end
        end
      end
      default: w_next = S_HALTED;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_tx_start     <= 1'b0;
      o_tx_data      <= 8'h00;
      o_busy         <= 1'b0;
      o_program_done <= 1'b0;
      r_shift        <= '0;
      r_byte_cnt     <= '0;
      r_reg_cnt      <= '0;
    end else begin
      o_tx_start <= w_send;
      if (w_send)     o_tx_data      <= r_shift[DATA_WIDTH-1 -: 8];
      if (w_set_done) o_program_done <= 1'b1;
      if (w_dump_start)    o_busy <= 1'b1;
      else if (w_dump_end) o_busy <= 1'b0;
      if (w_latch) begin
        r_shift    <= i_reg_content;
        r_byte_cnt <= BW'(NB - 1);
      end else if (w_shift) begin
        r_shift    <= r_shift << 8;
        r_byte_cnt <= r_byte_cnt - BW'(1);
      end
      if (w_dump_end)      r_reg_cnt <= '0;
      else if (w_next_reg) r_reg_cnt <= r_reg_cnt + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_debug_run_controller.sv
// tb/tb_debug_run_controller.sv - directed bench for debug_run_controller
module tb_debug_run_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        program_end;
  logic [31:0] reg_content;
  logic        halt;
  logic [4:0]  reg_read;
  logic        busy;
  logic        program_done;

  always #5 clk = ~clk;

  debug_run_controller #(.NUM_REGS(32), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_tx_busy(tx_busy), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .i_program_end(program_end), .i_reg_content(reg_content), .o_halt(halt),
    .o_reg_read(reg_read), .o_busy(busy), .o_program_done(program_done)
  );

  logic [31:0] bank [0:31];
  assign reg_content = bank[reg_read];

  // Transmitter model: busy for 10 cycles after each start, plus a forced hold.
  int   busy_left = 0;
  logic model_busy;
  logic hold;
  assign model_busy = (busy_left > 0);
  assign tx_busy    = model_busy | hold;
  always @(posedge clk) begin
    if (tx_start)           busy_left <= 10;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end

  logic [7:0] q[$];
  int nstart = 0;
  int viol = 0;
  int halt_low = 0;
  always @(negedge clk) begin
    if (tx_start) begin
      q.push_back(tx_data);
      nstart = nstart + 1;
      if (model_busy) viol = viol + 1;
    end
    if (!halt) halt_low = halt_low + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 6000) begin
      cyc();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_bytes(input int k, input string tag);
    int n = 0;
    while (q.size() < k && n < 3000) begin
      cyc();
      n++;
    end
    chk(tag, q.size(), k);
  endtask

  task automatic chk_dump(input string tag, input bit distinct);
    logic [7:0] e;
    chk({tag, "_count"}, q.size(), 128);
    for (int i = 0; i < 128 && i < q.size(); i++) begin
      e = distinct ? 8'(i / 4 + 64 * (i % 4)) : 8'(i / 4);
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, q[i]}, {24'd0, e});
    end
  endtask

  int snap;

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; program_end = 1'b0; hold = 1'b0;
    for (int k = 0; k < 32; k++) bank[k] = k * 32'h01010101;
    repeat (3) cyc();
    chk("rst_halt", {31'd0, halt}, 1);
    chk("rst_tx_start", {31'd0, tx_start}, 0);
    chk("rst_tx_data", {24'd0, tx_data}, 0);
    chk("rst_reg_read", {27'd0, reg_read}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, program_done}, 0);
    rst = 1'b0;
    cyc();

    // Single step: one low cycle of halt, no transmit.
    halt_low = 0;
    send(8'h53);
    chk("step_halt_low", {31'd0, halt}, 0);
    cyc();
    chk("step_halt_back", {31'd0, halt}, 1);
    repeat (5) cyc();
    chk("step_low_cycles", halt_low, 1);
    chk("step_no_tx", nstart, 0);

    // Run for 20 cycles, unknown 'A' ignored, then halt.
    halt_low = 0;
    send(8'h43);
    repeat (9) cyc();
    send(8'h41);
    chk("run_after_A", {31'd0, halt}, 0);
    repeat (9) cyc();
    chk("run_before_H", {31'd0, halt}, 0);
    send(8'h48);
    chk("halt_after_H", {31'd0, halt}, 1);
    repeat (3) cyc();
    chk("run_low_cycles", halt_low, 20);

    // Full dump.
    q.delete();
    send(8'h52);
    chk("dump_busy", {31'd0, busy}, 1);
    chk("dump_halt", {31'd0, halt}, 1);
    wait_idle("dump_timeout");
    chk_dump("dump", 1'b0);
    chk("dump_reg_read_end", {27'd0, reg_read}, 0);
    chk("dump_halt_end", {31'd0, halt}, 1);

    // Transmitter stalled mid-dump.
    q.delete();
    send(8'h52);
    wait_bytes(10, "stall_reach10");
    hold = 1'b1;
    cyc();
    snap = nstart;
    repeat (100) cyc();
    chk("stall_no_start", nstart, snap);
    hold = 1'b0;
    wait_idle("stall_timeout");
    chk_dump("stall", 1'b0);

    // Program end in RUN beats a simultaneous 'H'.
    for (int k = 0; k < 32; k++)
      bank[k] = {8'(k), 8'(k + 64), 8'(k + 128), 8'(k + 192)};
    q.delete();
    send(8'h43);
    repeat (3) cyc();
    rx_data = 8'h48; rx_valid = 1'b1; program_end = 1'b1;
    cyc();
    rx_valid = 1'b0; program_end = 1'b0;
    chk("pend_halt", {31'd0, halt}, 1);
    chk("pend_done", {31'd0, program_done}, 1);
    chk("pend_busy", {31'd0, busy}, 1);
    wait_idle("pend_timeout");
    chk_dump("pend", 1'b1);
    send(8'h43);
    chk("pend_C_halt", {31'd0, halt}, 1);
    repeat (3) cyc();
    chk("pend_C_halt_later", {31'd0, halt}, 1);
    chk("pend_done_sticky", {31'd0, program_done}, 1);

    // Asynchronous reset after the 50th byte.
    q.delete();
    send(8'h52);
    wait_bytes(50, "areset_reach50");
    #2 rst = 1'b1;
    #1;
    chk("areset_halt", {31'd0, halt}, 1);
    chk("areset_tx_start", {31'd0, tx_start}, 0);
    chk("areset_tx_data", {24'd0, tx_data}, 0);
    chk("areset_reg_read", {27'd0, reg_read}, 0);
    chk("areset_busy", {31'd0, busy}, 0);
    chk("areset_done", {31'd0, program_done}, 0);
    cyc();
    rst = 1'b0;
    repeat (200) cyc();
    chk("areset_no_resume", q.size(), 50);
    chk("areset_idle", {31'd0, busy}, 0);
    chk("no_start_while_busy", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
